nios_ram_arbiter: RTL

Two-port round-robin arbiter sharing one single-port on-chip RAM (32-bit, 10240 words, byte-enabled, one-cycle read latency) between two Avalon-MM masters, e.g. the Nios data master and a DMA engine. Sits between the interconnect slave ports and the RAM's address/byteenable/chipselect/write/writedata/readdata pins. It grants at most one access per cycle, stalls the loser with waitrequest, and routes pipelined read data back to the issuing port with readdatavalid.

---
 rtl/nios_ram_arb_pkg.sv | 18 +
 rtl/nios_ram_rd_tag_pipe.sv | 38 +++
 rtl/nios_ram_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/nios_ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package nios_ram_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = 4;
    localparam int RD_LAT_DEF = 1;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port_id;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, port_id: 1'b0};

endpackage

// File: rtl/nios_ram_rd_tag_pipe.sv
// Read tag delay line: carries {valid, port} alongside the RAM read latency.
module nios_ram_rd_tag_pipe
    import nios_ram_arb_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [RD_LAT];
    rd_tag_t stage_d [RD_LAT];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset drops in-flight tags so their data never reaches a master.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= RD_TAG_IDLE;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/nios_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
module nios_ram_arbiter
    import nios_ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = BE_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] avs0_address,
    input  logic [BE_W-1:0]   avs0_byteenable,
    input  logic              avs0_read,
    input  logic              avs0_write,
    input  logic [DATA_W-1:0] avs0_writedata,
    output logic              avs0_waitrequest,
    output logic [DATA_W-1:0] avs0_readdata,
    output logic              avs0_readdatavalid,

    input  logic [ADDR_W-1:0] avs1_address,
    input  logic [BE_W-1:0]   avs1_byteenable,
    input  logic              avs1_read,
    input  logic              avs1_write,
    input  logic [DATA_W-1:0] avs1_writedata,
    output logic              avs1_waitrequest,
    output logic [DATA_W-1:0] avs1_readdata,
    output logic              avs1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic     req0;
    logic     req1;
    logic     any_req;
    logic     both_req;
    port_id_t gnt_id;
    port_id_t last_q;
    port_id_t last_d;
    logic     gnt_write;
    logic     gnt_read;
    rd_tag_t  tag_in;
    rd_tag_t  tag_out;

    // On a tie the port that did not win last time gets the RAM.
    always_comb begin
        req0     = avs0_read | avs0_write;
        req1     = avs1_read | avs1_write;
        any_req  = req0 | req1;
        both_req = req0 & req1;
        gnt_id   = 1'b0;
        if (both_req) begin
            gnt_id = ~last_q;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
        last_d = any_req ? gnt_id : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // With no request the RAM pins idle on port 0's values.
    always_comb begin
        ram_address    = avs0_address;
        ram_byteenable = avs0_byteenable;
        ram_writedata  = avs0_writedata;
        gnt_write      = avs0_write;
        gnt_read       = avs0_read;
        if (any_req && gnt_id) begin
            ram_address    = avs1_address;
            ram_byteenable = avs1_byteenable;
            ram_writedata  = avs1_writedata;
            gnt_write      = avs1_write;
            gnt_read       = avs1_read;
        end
        ram_chipselect   = any_req;
        ram_write        = any_req & gnt_write;
        avs0_waitrequest = both_req & gnt_id;
        avs1_waitrequest = both_req & ~gnt_id;
        // Read with write also asserted is a write; no data comes back.
        tag_in           = '{valid: any_req & gnt_read & ~gnt_write, port_id: gnt_id};
    end

    nios_ram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign avs0_readdatavalid = tag_out.valid & (tag_out.port_id == 1'b0);
    assign avs1_readdatavalid = tag_out.valid & (tag_out.port_id == 1'b1);
    assign avs0_readdata      = ram_readdata;
    assign avs1_readdata      = ram_readdata;
    assign ram_clken          = 1'b1;

endmodule
